// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe: pipelined barrel shifter (SLL / SRL / SRA / ROR).
//
// One register stage per shift-amount bit. Stage k shifts by 2^k when its
// amount bit is set, otherwise it passes the word through unchanged. Each
// stage carries its own valid bit, so empty stages fill even while the
// output is stalled.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Stage k is ready when it is empty or the stage after it is
// ready; the last stage is ready when out_ready is high; in_ready is stage
// 0's ready. Ready therefore ripples combinationally from out_ready back to
// in_ready, while valid only moves forward through registers, so there is
// no combinational path from in_valid to out_valid.
//
// Configuration macro SHIFT_UNIT_ROT_EN:
//   defined   - op 2'b11 rotates right.
//   undefined - no rotate datapath; op 2'b11 behaves as SRA and the result
//               is flagged on out_illegal (registered with the last stage).
module shift_unit_pipe #(
  parameter int  WIDTH = 32,
  parameter int  TAG_W = 5,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
`ifndef SHIFT_UNIT_ROT_EN
  ,
  output logic             out_illegal
`endif
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Per-stage pipeline registers.
  logic [SHW-1:0]   r_valid;
  logic [WIDTH-1:0] r_data [SHW];
  logic [SHW-1:0]   r_amt  [SHW];
  logic [1:0]       r_op   [SHW];
  logic [TAG_W-1:0] r_tag  [SHW];
  logic             r_sign [SHW];

  // Result flags, only meaningful alongside the last stage.
  logic             r_zero;
`ifndef SHIFT_UNIT_ROT_EN
  logic             r_ill;
`endif

  // Inputs seen by each stage (stage 0 sees the ports, stage k sees k-1).
  logic [SHW-1:0]   w_src_valid;
  logic [WIDTH-1:0] w_src_data  [SHW];
  logic [SHW-1:0]   w_src_amt   [SHW];
  logic [1:0]       w_src_op    [SHW];
  logic [TAG_W-1:0] w_src_tag   [SHW];
  logic             w_src_sign  [SHW];
  logic [WIDTH-1:0] w_shifted   [SHW];
  logic [SHW-1:0]   w_ready;

  // Shift a word by a fixed power-of-two amount. The SRA fill comes from the
  // sign captured at entry, never from the partially shifted word, so that a
  // preceding stage's zero fill cannot corrupt it.
  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sgn,
    input int               s
  );
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] res;
    fill_mask = ~({WIDTH{1'b1}} >> s);
    res       = '0;
    case (op)
      OP_SLL:  res = d << s;
      OP_SRL:  res = d >> s;
      OP_SRA:  res = (d >> s) | (sgn ? fill_mask : '0);
`ifdef SHIFT_UNIT_ROT_EN
      OP_ROR:  res = (d >> s) | (d << (WIDTH - s));
`else
      OP_ROR:  res = (d >> s) | (sgn ? fill_mask : '0);
`endif
      default: res = d;
    endcase
    return res;
  endfunction

  // Ready chain: a stage can take a new word if it, or any stage between it
  // and the output, is empty, or if the consumer is taking the output.
  always_comb begin
    logic acc;
    w_ready = '0;
    acc     = out_ready;
    for (int k = SHW - 1; k >= 0; k--) begin
      acc        = acc | ~r_valid[k];
      w_ready[k] = acc;
    end
  end

  // Route each stage's source fields and compute its shifted word.
  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    w_src_amt[0]   = in_amt;
    w_src_op[0]    = in_op;
    w_src_tag[0]   = in_tag;
    w_src_sign[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHW; k++) begin
      w_src_valid[k] = r_valid[k-1];
      w_src_data[k]  = r_data[k-1];
      w_src_amt[k]   = r_amt[k-1];
      w_src_op[k]    = r_op[k-1];
      w_src_tag[k]   = r_tag[k-1];
      w_src_sign[k]  = r_sign[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      if (w_src_amt[k][k]) begin
        w_shifted[k] = stage_shift(w_src_data[k], w_src_op[k], w_src_sign[k], 1 << k);
      end else begin
        w_shifted[k] = w_src_data[k];
      end
    end
  end

  // Stage registers: load whenever the stage is ready; payload only moves
  // with a valid word so a stalled or drained stage keeps its contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= '0;
        r_amt[k]  <= '0;
        r_op[k]   <= '0;
        r_tag[k]  <= '0;
        r_sign[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (w_ready[k]) begin
          r_valid[k] <= w_src_valid[k];
          if (w_src_valid[k]) begin
            r_data[k] <= w_shifted[k];
            r_amt[k]  <= w_src_amt[k];
            r_op[k]   <= w_src_op[k];
            r_tag[k]  <= w_src_tag[k];
            r_sign[k] <= w_src_sign[k];
          end
        end
      end
    end
  end

  // Result flags are computed from the last stage's inputs and registered
  // with it, so they change exactly when out_data changes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_zero <= 1'b0;
`ifndef SHIFT_UNIT_ROT_EN
      r_ill  <= 1'b0;
`endif
    end else if (w_ready[SHW-1] && w_src_valid[SHW-1]) begin
      r_zero <= (w_shifted[SHW-1] == '0);
`ifndef SHIFT_UNIT_ROT_EN
      r_ill  <= (w_src_op[SHW-1] == OP_ROR);
`endif
    end
  end

  assign in_ready  = w_ready[0];
  assign out_valid = r_valid[SHW-1];
  assign out_data  = r_data[SHW-1];
  assign out_tag   = r_tag[SHW-1];
  assign out_zero  = r_zero;
`ifndef SHIFT_UNIT_ROT_EN
  assign out_illegal = r_ill;
`endif

endmodule

// File: tb/tb_shift_unit_pipe.sv
// tb_shift_unit_pipe: directed bench for shift_unit_pipe (WIDTH=32).
// Works with SHIFT_UNIT_ROT_EN defined or undefined.
module tb_shift_unit_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int SHW   = 5;
  localparam int EW    = WIDTH + TAG_W + 2;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_illegal;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  shift_unit_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_amt      (in_amt),
    .in_op       (in_op),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_zero    (out_zero)
`ifndef SHIFT_UNIT_ROT_EN
    ,
    .out_illegal (out_illegal)
`endif
  );

`ifdef SHIFT_UNIT_ROT_EN
  assign out_illegal = 1'b0;
`endif

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            checks = 0;
  int            errors = 0;
  logic          chk_lat = 1'b0;
  logic          hold_v = 1'b0;
  logic [WIDTH-1:0] hold_data;
  logic [TAG_W-1:0] hold_tag;
  logic          hold_zero;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model used for the generated streams.
  function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                             input int amt);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00: r = d << amt;
      2'b01: r = d >> amt;
`ifdef SHIFT_UNIT_ROT_EN
      2'b11: r = (amt == 0) ? d : ((d >> amt) | (d << (WIDTH - amt)));
`endif
      default: r = WIDTH'($signed(d) >>> amt);
    endcase
    return r;
  endfunction

  // Output monitor: compare every emitted result, its latency, and hold
  // stability while the consumer stalls.
  always @(negedge clock) begin
    logic [EW-1:0] e;
    int a;
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0h tag %0d, expected no output", out_data, out_tag);
        end else begin
          e = exp_q.pop_front();
          a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          chk("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
          chk("out_tag", 64'(out_tag), 64'(e[WIDTH+TAG_W-1:WIDTH]));
          chk("out_zero", 64'(out_zero), 64'(e[WIDTH+TAG_W]));
          chk("out_illegal", 64'(out_illegal), 64'(e[WIDTH+TAG_W+1]));
          if (chk_lat) chk("latency", 64'(cyc - a), 64'(SHW));
        end
      end
      if (out_valid && !out_ready) begin
        if (hold_v) begin
          chk("hold_data", 64'(out_data), 64'(hold_data));
          chk("hold_tag", 64'(out_tag), 64'(hold_tag));
          chk("hold_zero", 64'(out_zero), 64'(hold_zero));
        end
        hold_v    = 1'b1;
        hold_data = out_data;
        hold_tag  = out_tag;
        hold_zero = out_zero;
      end else begin
        hold_v = 1'b0;
      end
      if (in_valid && in_ready) acc_q.push_back(cyc);
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Present one operation (called at posedge+1); returns at posedge+1 after
  // the edge that accepted it, leaving in_valid high for back-to-back use.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d, input logic [SHW-1:0] amt,
                      input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp_d,
                      input logic exp_z, input logic exp_i);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_amt   = amt;
    in_tag   = tag;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = in_ready;
      if (acc) exp_q.push_back({exp_i, exp_z, tag, exp_d});
      @(posedge clock);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ill;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int n_acc;
    logic [WIDTH-1:0] d;

    vecs[0]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1, 1'b0};
`ifdef SHIFT_UNIT_ROT_EN
    vecs[4]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0};
    vecs[14] = '{2'b11, 32'hA5A5_A5A5, 5'd31, 32'h4B4B_4B4B, 1'b0, 1'b0};
`else
    vecs[4]  = '{2'b11, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b1};
    vecs[5]  = '{2'b11, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b1};
    vecs[6]  = '{2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b1};
    vecs[14] = '{2'b11, 32'hA5A5_A5A5, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b1};
`endif
    vecs[7]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 1'b0, 1'b0};
    vecs[9]  = '{2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1'b0, 1'b0};
    vecs[10] = '{2'b00, 32'h0000_00FF, 5'd8,  32'h0000_FF00, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b0};
    vecs[12] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    vecs[13] = '{2'b10, 32'h8000_0001, 5'd5,  32'hFC00_0000, 1'b0, 1'b0};
    vecs[15] = '{2'b00, 32'h1234_5678, 5'd12, 32'h4567_8000, 1'b0, 1'b0};

    // Reset state.
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    reset = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Table vectors, one at a time.
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].data, vecs[i].amt, TAG_W'(i), vecs[i].res, vecs[i].zero, vecs[i].ill);
      in_valid = 1'b0;
      wait_drain(20);
    end

    // Streaming: back-to-back SRA with tags 1..8.
    for (int i = 1; i <= 8; i++) begin
      d = 32'h8000_0000 | WIDTH'(i * 32'h0101);
      send(2'b10, d, SHW'(i), TAG_W'(i), model(2'b10, d, i), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    wait_drain(30);

    // Backpressure: output stalled, input offered every cycle.
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    n_acc     = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_op    = 2'b00;
      in_data  = WIDTH'(n_acc + 3);
      in_amt   = SHW'(n_acc);
      in_tag   = TAG_W'(n_acc + 10);
      @(negedge clock);
      if (in_ready) begin
        exp_q.push_back({1'b0, 1'b0, TAG_W'(n_acc + 10), model(2'b00, WIDTH'(n_acc + 3), n_acc)});
        n_acc++;
      end
      @(posedge clock);
      #1;
    end
    chk("bp_accepted", 64'(n_acc), 64'(SHW));
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain(30);

    // Reset mid-stream with three items in flight.
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(2'b01, 32'hFFFF_0000, SHW'(i), TAG_W'(20 + i), model(2'b01, 32'hFFFF_0000, i), 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_tag", 64'(out_tag), 64'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    send(2'b00, 32'h0000_0003, 5'd4, 5'd7, 32'h0000_0030, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_drain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
